// File: rtl/lcd_timed_ctrl_pkg.sv
// Shared types and constants for the timed HD44780 LCD controller.
package lcd_timed_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EHIGH,
        HOLD,
        DONE
    } state_t;

    // Avalon address bits (same map as the original bit-banged LCD slave)
    localparam int RW_BIT = 0;
    localparam int RS_BIT = 1;

    // Busy flag position in the HD44780 status byte
    localparam int BF_BIT = 7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// A phase of N cycles is timed by loading N-1 on entry.
module lcd_phase_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    // Count down to zero and park there until reloaded
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign tc = (count == '0);

endmodule

// File: rtl/lcd_timed_ctrl.sv
// Avalon-MM slave turning each access into one fully timed HD44780 bus
// cycle, with optional 4-bit transfers and busy-flag polling after writes.
module lcd_timed_ctrl
    import lcd_timed_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int T_SETUP    = 2,
    parameter int T_EHIGH    = 12,
    parameter int T_HOLD     = 30,
    parameter int BUSY_POLL  = 0,
    parameter int POLL_LIMIT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [7:0]           writedata,
    output logic [7:0]           readdata,
    output logic                 waitrequest,
    output logic                 timeout,
    output logic                 LCD_E,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    inout  wire  [BUS_WIDTH-1:0] LCD_data
);

    localparam int TW = $clog2(max3(T_SETUP, T_EHIGH, T_HOLD) + 1);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [1:0]    NIBBLES  = (BUS_WIDTH == 4) ? 2'd2 : 2'd1;
    localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP - 1);
    localparam logic [TW-1:0] LD_EHIGH = TW'(T_EHIGH - 1);
    localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD - 1);
    localparam logic [PW-1:0] LAST_POLL = PW'(POLL_LIMIT - 1);

    state_t          state, next_state;
    logic            req, tc, tload;
    logic [TW-1:0]   tval;
    logic            lat_rs, lat_rw, lat_rd;
    logic [7:0]      lat_data;
    logic [1:0]      nib_rem;
    logic            polling, status_bf;
    logic [PW-1:0]   poll_cnt;
    logic            active, eff_rw, eff_rs, drive;
    logic            more_nib, start_poll, poll_again, capture;
    logic [7:0]      bus_in;
    logic [BUS_WIDTH-1:0] out_val;

    // Merge a captured byte or nibble into the previous readdata value
    function automatic logic [7:0] capture_byte(input logic [7:0] old, input logic [7:0] bus,
                                                input logic [1:0] nib);
        if (BUS_WIDTH == 4)
            return (nib == 2'd2) ? {bus[3:0], old[3:0]} : {old[7:4], bus[3:0]};
        return bus;
    endfunction

    assign req        = read | write;
    assign active     = (state == SETUP) || (state == EHIGH) || (state == HOLD);
    // Status reads override the latched access with RS=0, RW=1
    assign eff_rw     = polling | lat_rw;
    assign eff_rs     = ~polling & lat_rs;
    assign more_nib   = (nib_rem != 2'd1);
    assign start_poll = (BUSY_POLL != 0) && !polling && !lat_rw && !more_nib;
    assign poll_again = polling && !more_nib && status_bf && (poll_cnt != LAST_POLL);
    assign capture    = (state == EHIGH) && tc && eff_rw;
    assign bus_in     = 8'(LCD_data);

    lcd_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tload),
        .load_val (tval),
        .tc       (tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic and phase timer loading
    always_comb begin
        next_state = state;
        tload      = 1'b0;
        tval       = LD_SETUP;
        case (state)
            IDLE: if (req) begin
                next_state = SETUP;
                tload      = 1'b1;
            end
            SETUP: if (tc) begin
                next_state = EHIGH;
                tload      = 1'b1;
                tval       = LD_EHIGH;
            end
            EHIGH: if (tc) begin
                next_state = HOLD;
                tload      = 1'b1;
                tval       = LD_HOLD;
            end
            HOLD: if (tc) begin
                if (more_nib || start_poll || poll_again) begin
                    next_state = SETUP;
                    tload      = 1'b1;
                end else begin
                    // A request withdrawn mid-cycle skips the handshake
                    next_state = req ? DONE : IDLE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control registers: access latch, nibble/poll bookkeeping, readdata, timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_rs   <= 1'b0;
            lat_rw   <= 1'b1;
            lat_rd   <= 1'b0;
            nib_rem  <= 2'd1;
            polling  <= 1'b0;
            poll_cnt <= '0;
            readdata <= 8'h00;
            timeout  <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                lat_rs   <= address[RS_BIT];
                lat_rw   <= address[RW_BIT];
                lat_rd   <= read;
                nib_rem  <= NIBBLES;
                polling  <= 1'b0;
                poll_cnt <= '0;
            end
            if (capture && !polling && lat_rd)
                readdata <= capture_byte(readdata, bus_in, nib_rem);
            if (state == HOLD && tc) begin
                if (more_nib) begin
                    nib_rem <= nib_rem - 2'd1;
                end else if (start_poll) begin
                    polling  <= 1'b1;
                    nib_rem  <= NIBBLES;
                    poll_cnt <= '0;
                end else if (polling) begin
                    poll_cnt <= poll_cnt + 1'b1;
                    nib_rem  <= NIBBLES;
                    if (!status_bf)
                        timeout <= 1'b0;
                    else if (poll_cnt == LAST_POLL)
                        timeout <= 1'b1;
                end
            end
        end
    end

    // Data latches: write byte and busy flag (BF arrives with the first nibble)
    always_ff @(posedge clk) begin
        if (state == IDLE && req)
            lat_data <= writedata;
        if (capture && polling && (NIBBLES == 2'd1 || nib_rem == 2'd2))
            status_bf <= (BUS_WIDTH == 4) ? bus_in[BF_BIT-4] : bus_in[BF_BIT];
    end

    assign out_val = (BUS_WIDTH == 4)
                   ? BUS_WIDTH'((nib_rem == 2'd2) ? lat_data[7:4] : lat_data[3:0])
                   : BUS_WIDTH'(lat_data);
    assign drive       = active & ~eff_rw;
    assign LCD_data    = drive ? out_val : 'z;
    assign LCD_E       = (state == EHIGH);
    assign LCD_RS      = active & eff_rs;
    assign LCD_RW      = ~active | eff_rw;
    assign waitrequest = req & (state != DONE);

endmodule
